fadd_acc_seq: RTL and testbench

- Sequencer that sits directly upstream of FAdd and also consumes its result. It turns a stream of IEEE-754 single-precision samples into a running sum/difference.
- Drives FAdd's in1 with the accumulator and in2 with each sample, and sets op per sample.
- Waits out FAdd's pipeline latency, captures FAdd's out back into the accumulator, and emits the final value when the last sample of a group is processed.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fadd_acc_seq.sv | 121 ++++++++++++
 tb/tb_fadd_acc_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Shared single-precision constants, FAdd opcodes and the
//             state encoding of the accumulation sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int          FP_W        = 32;
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    // FAdd operation select
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fadd_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fadd_acc_seq
//  Purpose  : Feeds FAdd with (accumulator, sample) pairs, waits out its
//             pipeline latency and folds the result back into the
//             accumulator; emits the group sum when the last sample lands.
//  Revision : 1.0  initial release
// ============================================================================
module fadd_acc_seq
    import fp_pkg::*;
#(
    parameter int ADD_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic [31:0]      add_in1,
    output logic [31:0]      add_in2,
    output logic             add_op,
    input  logic [31:0]      add_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_cnt
);

    // Wait counter only has to hold ADD_LAT-1; keep at least one bit.
    localparam int                  c_WAIT_W    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(ADD_LAT - 1);

    seq_state_t           r_state;
    seq_state_t           w_next_state;
    logic [FP_W-1:0]      r_acc;
    logic [FP_W-1:0]      r_sample;
    logic                 r_op;
    logic                 r_last;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]     r_count;
    logic [FP_W-1:0]      r_out_data;
    logic [CNT_W-1:0]     r_out_cnt;

    logic                 w_accept;
    logic                 w_capture;
    logic                 w_release;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_capture = (r_state == ST_WAIT) && (r_wait_cnt == '0);
    assign w_release = (r_state == ST_DONE) && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next_state = ST_WAIT;
            ST_WAIT: if (w_capture) w_next_state = r_last ? ST_DONE : ST_IDLE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: latch samples, time the FAdd latency, fold results back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= FP_POS_ZERO;
            r_sample   <= '0;
            r_op       <= OP_ADD;
            r_last     <= 1'b0;
            r_wait_cnt <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_out_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_sample   <= in_data;
                r_op       <= in_sub ? OP_SUB : OP_ADD;
                r_last     <= in_last;
                r_wait_cnt <= c_WAIT_LOAD;
                r_count    <= r_count + CNT_W'(1);
            end
            if (r_state == ST_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - c_WAIT_W'(1);
            end
            // FAdd's result is taken bit-exactly; no float handling here.
            if (w_capture) begin
                r_acc <= add_out;
                if (r_last) begin
                    r_out_data <= add_out;
                    r_out_cnt  <= r_count;
                end
            end
            if (w_release) begin
                r_acc   <= FP_POS_ZERO;
                r_count <= '0;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign add_in1   = r_acc;
    assign add_in2   = r_sample;
    assign add_op    = r_op;
    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;

endmodule : fadd_acc_seq
`default_nettype wire

// File: tb/tb_fadd_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fadd_acc_seq
//  Purpose  : Self-checking bench for fadd_acc_seq with a behavioural FAdd
//             model (ADD_LAT = 2) and a scoreboard of group results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fadd_acc_seq;

    localparam int ADD_LAT = 2;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             in_sub = 1'b0;
    logic             in_last = 1'b0;
    logic [31:0]      add_in1;
    logic [31:0]      add_in2;
    logic             add_op;
    logic [31:0]      add_out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_cnt;

    fadd_acc_seq #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .add_in1   (add_in1),
        .add_in2   (add_in2),
        .add_op    (add_op),
        .add_out   (add_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural FAdd (normals and zero only) -------------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic op);
        real ra, rb;
        ra = f2r(a);
        rb = f2r(b);
        return r2f(op ? (ra - rb) : (ra + rb));
    endfunction

    // ADD_LAT = 2: inputs issued after edge N are seen on add_out after N+1,
    // in time for the sequencer's capture at edge N+2.
    logic [31:0] fadd_q = '0;
    always @(posedge clk) fadd_q <= fadd_model(add_in1, add_in2, add_op);
    assign add_out = fadd_q;

    // ---------------- checking infrastructure ------------------------------
    typedef struct {
        logic [31:0] data;
        logic [15:0] cnt;
    } res_t;

    typedef struct {
        logic [31:0] data;
        logic        sub;
        logic        last;
        logic [31:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    res_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One clock: monitor the output handshake on the falling edge, then
    // step past the rising edge.
    task automatic tick();
        res_t r;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", out_data, 32'hDEADBEEF);
            end else begin
                r = sb_q.pop_front();
                chk("out_data", out_data, r.data);
                chk("out_cnt", 32'(out_cnt), 32'(r.cnt));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int   n;
        logic held_ok;

        vecs[0] = '{32'h40000000, 1'b0, 1'b0, 32'h0,        16'd0};
        vecs[1] = '{32'h3FE3D70A, 1'b0, 1'b1, 32'h4071EB85, 16'd2};
        vecs[2] = '{32'h41D26666, 1'b0, 1'b0, 32'h0,        16'd0};
        vecs[3] = '{32'h41D26666, 1'b1, 1'b1, 32'h00000000, 16'd2};
        vecs[4] = '{32'h40000000, 1'b1, 1'b1, 32'hC0000000, 16'd1};

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_add_in1", add_in1, 32'h0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_out_data", out_data, 32'h0);

        // Table-driven groups with consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].last) sb_q.push_back('{vecs[i].exp_data, vecs[i].exp_cnt});
            send(vecs[i].data, vecs[i].sub, vecs[i].last);
        end
        drain();
        tick();
        chk("acc_cleared", add_in1, 32'h0);

        // Latency of a lone subtract, then stall the consumer in DONE
        out_ready = 1'b0;
        sb_q.push_back('{32'hC0000000, 16'd1});
        send(32'h40000000, 1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("done_latency", 32'(n), 32'(ADD_LAT));

        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        in_sub   = 1'b0;
        in_last  = 1'b1;
        held_ok  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (in_ready || !out_valid || out_data != 32'hC0000000) held_ok = 1'b0;
        end
        chk("done_hold", 32'(held_ok), 32'd1);
        chk("done_hold_data", out_data, 32'hC0000000);
        chk("done_hold_cnt", 32'(out_cnt), 32'd1);

        out_ready = 1'b1;
        tick();
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_acc", add_in1, 32'h0);
        sb_q.push_back('{32'h3F800000, 16'd1});
        tick();
        in_valid = 1'b0;
        chk("accepted_next", 32'(in_ready), 32'd0);
        chk("accepted_sample", add_in2, 32'h3F800000);
        drain();

        // Reset while FAdd has an operation in flight
        send(32'h40000000, 1'b0, 1'b0);
        send(32'h40000000, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wait_rst_in_ready", 32'(in_ready), 32'd1);
        chk("wait_rst_acc", add_in1, 32'h0);
        chk("wait_rst_out_valid", 32'(out_valid), 32'd0);
        sb_q.push_back('{32'h3F800000, 16'd1});
        send(32'h3F800000, 1'b0, 1'b1);
        drain();

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fadd_acc_seq
`default_nettype wire
